// File: rtl/io_bus_ctrl_if.sv
// Bundle of the driver-side, core-side and bus-side signals of io_bus_ctrl.
// master is the controller's view; slave is the surrounding driver/core/pad view.
interface io_bus_ctrl_if #(
  parameter int BUS_WIDTH = 48
);
  logic                 start;
  logic                 running;
  logic [BUS_WIDTH-1:0] io_bus_in;
  logic [BUS_WIDTH-1:0] io_bus_out;
  logic                 io_bus_oe;
  logic                 a_valid;
  logic                 a_ready;
  logic                 b_valid;
  logic                 b_ready;
  logic [BUS_WIDTH-1:0] a_word;
  logic                 a_word_valid;
  logic                 a_word_ready;
  logic [BUS_WIDTH-1:0] b_word;
  logic                 b_word_valid;
  logic                 b_word_ready;
  logic [BUS_WIDTH-1:0] res_word;
  logic                 res_valid;
  logic                 res_ready;
  logic                 core_done;
  logic                 output_valid;
  logic                 done;

  modport master (
    input  start, io_bus_in, a_valid, b_valid, a_word_ready, b_word_ready,
           res_word, res_valid, core_done,
    output running, io_bus_out, io_bus_oe, a_ready, b_ready, a_word, a_word_valid,
           b_word, b_word_valid, res_ready, output_valid, done
  );

  modport slave (
    output start, io_bus_in, a_valid, b_valid, a_word_ready, b_word_ready,
           res_word, res_valid, core_done,
    input  running, io_bus_out, io_bus_oe, a_ready, b_ready, a_word, a_word_valid,
           b_word, b_word_valid, res_ready, output_valid, done
  );
endinterface

// File: rtl/io_bus_ctrl.sv
// Half-duplex shared-bus controller: receives feature/kernel words from the driver,
// buffers core results and turns the bus around to send them back.
module io_bus_ctrl #(
  parameter int BUS_WIDTH      = 48,
  parameter int RES_FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          arst_n,
  io_bus_ctrl_if.master bus
);
  localparam int PTR_W = $clog2(RES_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {IDLE, RX, TURN_TX, TX, TURN_RX, FIN} state_t;

  state_t               state_q, state_d;
  logic [BUS_WIDTH-1:0] a_word_q, b_word_q;
  logic                 a_full_q, b_full_q;
  logic [BUS_WIDTH-1:0] fifo_mem [RES_FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q;

  logic fifo_full, fifo_empty;
  logic a_ready, b_ready, res_ready;
  logic a_acc, b_acc, push, pop;

  assign fifo_full  = (count_q == CNT_W'(RES_FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign res_ready  = ~fifo_full & (state_q != IDLE);
  assign push       = bus.res_valid & res_ready;
  assign a_acc      = bus.a_valid & a_ready;
  assign b_acc      = bus.b_valid & b_ready;

  always_comb begin
    state_d = state_q;
    a_ready = 1'b0;
    b_ready = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (bus.start) state_d = RX;
      RX: begin
        // a has fixed priority: b is only offered while a is not requesting
        a_ready = ~a_full_q | bus.a_word_ready;
        b_ready = (~b_full_q | bus.b_word_ready) & ~bus.a_valid;
        if (fifo_full || (!fifo_empty && !bus.a_valid && !bus.b_valid))
          state_d = TURN_TX;
        else if (bus.core_done && fifo_empty && !bus.res_valid)
          state_d = FIN;
      end
      TURN_TX: state_d = TX;
      TX: begin
        pop = ~fifo_empty;
        if (count_q == CNT_W'(1) && !push) state_d = TURN_RX;
      end
      TURN_RX: state_d = RX;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      a_word_q <= '0;
      b_word_q <= '0;
      a_full_q <= 1'b0;
      b_full_q <= 1'b0;
    end else if (state_q == FIN) begin
      a_full_q <= 1'b0;
      b_full_q <= 1'b0;
    end else begin
      if (a_acc) begin
        a_word_q <= bus.io_bus_in;
        a_full_q <= 1'b1;
      end else if (bus.a_word_ready) begin
        a_full_q <= 1'b0;
      end
      if (b_acc) begin
        b_word_q <= bus.io_bus_in;
        b_full_q <= 1'b1;
      end else if (bus.b_word_ready) begin
        b_full_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (state_q == FIN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the head is only visible while the bus is driven.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.res_word;
  end

  assign bus.running      = (state_q != IDLE);
  assign bus.io_bus_oe    = (state_q == TX);
  assign bus.output_valid = (state_q == TX);
  assign bus.io_bus_out   = (state_q == TX) ? fifo_mem[rd_ptr_q] : '0;
  assign bus.done         = (state_q == FIN);
  assign bus.a_ready      = a_ready;
  assign bus.b_ready      = b_ready;
  assign bus.res_ready    = res_ready;
  assign bus.a_word       = a_word_q;
  assign bus.a_word_valid = a_full_q;
  assign bus.b_word       = b_word_q;
  assign bus.b_word_valid = b_full_q;
endmodule

// File: tb/tb_io_bus_ctrl.sv
// Self-checking bench for io_bus_ctrl: directed scenarios plus randomized traffic
// scored against a queue-based model of the stream and result buffers.
module tb_io_bus_ctrl;
  localparam int W     = 48;
  localparam int DEPTH = 4;

  logic clk    = 1'b0;
  logic arst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  io_bus_ctrl_if #(.BUS_WIDTH(W)) bus ();

  io_bus_ctrl #(.BUS_WIDTH(W), .RES_FIFO_DEPTH(DEPTH)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [W-1:0] res_q[$];
  logic [W-1:0] ma_d, mb_d, exp_word;
  bit mrun, ma_v, mb_v;
  bit prev_oe, prev_ar, prev_br, prev_done, prev_fin, fin_now;

  always @(negedge clk) begin
    if (!arst_n) begin
      check_eq("rst_outputs", 64'({bus.running, bus.io_bus_oe, bus.output_valid, bus.done,
               bus.a_ready, bus.b_ready, bus.res_ready, bus.a_word_valid, bus.b_word_valid}), 64'(0));
      check_eq("rst_bus_out", 64'(bus.io_bus_out), 64'(0));
      res_q.delete();
      mrun = 0; ma_v = 0; mb_v = 0;
      prev_oe = 0; prev_ar = 0; prev_br = 0; prev_done = 0; prev_fin = 0;
    end else begin
      check_eq("running", 64'(bus.running), 64'(mrun));
      check_eq("res_ready", 64'(bus.res_ready), 64'(mrun && (res_q.size() < DEPTH)));
      check_eq("a_word_valid", 64'(bus.a_word_valid), 64'(ma_v));
      if (ma_v) check_eq("a_word", 64'(bus.a_word), 64'(ma_d));
      check_eq("b_word_valid", 64'(bus.b_word_valid), 64'(mb_v));
      if (mb_v) check_eq("b_word", 64'(bus.b_word), 64'(mb_d));
      check_eq("out_valid_vs_oe", 64'(bus.output_valid), 64'(bus.io_bus_oe));
      if (!bus.io_bus_oe) check_eq("bus_out_idle", 64'(bus.io_bus_out), 64'(0));
      if (bus.b_ready) check_eq("b_ready_with_a_valid", 64'(bus.a_valid), 64'(0));
      if (bus.io_bus_oe) check_eq("contention", 64'({bus.a_ready, bus.b_ready}), 64'(0));
      if (bus.io_bus_oe && !prev_oe) check_eq("turn_tx_gap", 64'({prev_ar, prev_br}), 64'(0));
      if (!bus.io_bus_oe && prev_oe) check_eq("turn_rx_gap", 64'({bus.a_ready, bus.b_ready}), 64'(0));
      if (prev_done) check_eq("done_pulse", 64'(bus.done), 64'(0));
      if (bus.done) check_eq("done_cause", 64'(prev_fin), 64'(1));
      fin_now = mrun && bus.core_done && (res_q.size() == 0) && !bus.res_valid;
      if (bus.output_valid) begin
        check_eq("tx_has_data", 64'(res_q.size() != 0), 64'(1));
        if (res_q.size() != 0) begin
          exp_word = res_q.pop_front();
          check_eq("tx_word", 64'(bus.io_bus_out), 64'(exp_word));
          $display("tx word %h", exp_word);
        end
      end
      if (bus.res_valid && bus.res_ready) res_q.push_back(bus.res_word);
      if (bus.a_valid && bus.a_ready) begin
        ma_v = 1; ma_d = bus.io_bus_in;
      end else if (bus.a_word_ready) ma_v = 0;
      if (bus.b_valid && bus.b_ready) begin
        mb_v = 1; mb_d = bus.io_bus_in;
      end else if (bus.b_word_ready) mb_v = 0;
      if (bus.done) begin
        res_q.delete(); ma_v = 0; mb_v = 0; mrun = 0;
      end else if (!mrun && bus.start) mrun = 1;
      prev_oe = bus.io_bus_oe; prev_ar = bus.a_ready; prev_br = bus.b_ready;
      prev_done = bus.done; prev_fin = fin_now;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.a_valid = 0; bus.b_valid = 0; bus.res_valid = 0;
    bus.core_done = 0; bus.a_word_ready = 1; bus.b_word_ready = 1;
  endtask

  int   oe_cnt;
  bit   seen;
  logic [63:0] r1, r2;
  logic [W-1:0] wd;

  initial begin
    idle_inputs();
    bus.io_bus_in = '0; bus.res_word = '0;
    repeat (2) @(posedge clk);
    #3 arst_n = 1;
    repeat (2) tick();

    // Feature word accepted and presented one cycle later
    bus.start = 1; tick(); bus.start = 0;
    bus.a_valid = 1; bus.io_bus_in = 48'h0000_0001_0002; #2;
    check_eq("req35_a_ready", 64'(bus.a_ready), 64'(1));
    tick(); bus.a_valid = 0; #2;
    check_eq("req35_a_word_valid", 64'(bus.a_word_valid), 64'(1));
    check_eq("req35_a_word", 64'(bus.a_word), 64'h0000_0001_0002);

    // a wins over b in the same cycle
    tick(); bus.a_valid = 1; bus.b_valid = 1; bus.io_bus_in = 48'h1111_2222_3333; #2;
    check_eq("req36_a_ready", 64'(bus.a_ready), 64'(1));
    check_eq("req36_b_blocked", 64'(bus.b_ready), 64'(0));
    tick(); bus.a_valid = 0; bus.io_bus_in = 48'h4444_5555_6666; #2;
    check_eq("req36_b_ready", 64'(bus.b_ready), 64'(1));
    tick(); bus.b_valid = 0; #2;
    check_eq("req36_b_word", 64'(bus.b_word), 64'h4444_5555_6666);

    // Four results with an idle driver -> four TX cycles
    oe_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick(); bus.res_valid = 1; bus.res_word = W'(48'hA0 + i); #2;
      if (bus.io_bus_oe) oe_cnt++;
    end
    for (int i = 0; i < 16; i++) begin
      tick(); bus.res_valid = 0; #2;
      if (bus.io_bus_oe) oe_cnt++;
    end
    check_eq("req37_tx_cycles", 64'(oe_cnt), 64'(4));

    // FIFO fills while the driver keeps the bus busy
    wd = 48'hB00;
    for (int i = 0; i < 12; i++) begin
      tick(); bus.a_valid = 1; bus.io_bus_in = W'(48'hC00 + i);
      bus.res_valid = 1; bus.res_word = wd; #2;
      if (i == 4) check_eq("req38_full_ready", 64'(bus.res_ready), 64'(0));
      if (bus.res_ready) wd = wd + 1;
    end
    tick(); idle_inputs();
    repeat (20) tick();

    // core_done with empty FIFO ends the layer
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick(); bus.core_done = 1; #2;
      if (bus.done) seen = 1;
    end
    check_eq("req39_done_seen", 64'(seen), 64'(1));
    tick(); bus.core_done = 0; #2;
    check_eq("req39_running_low", 64'(bus.running), 64'(0));
    check_eq("req39_done_low", 64'(bus.done), 64'(0));
    tick(); bus.start = 1; tick(); bus.start = 0; #2;
    check_eq("req39_restart", 64'(bus.running), 64'(1));

    // Reset during TX releases the bus without a clock edge
    tick(); bus.res_valid = 1; bus.res_word = 48'hD0;
    tick(); bus.res_word = 48'hD1;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick(); bus.res_valid = 0; #2;
      if (bus.io_bus_oe) seen = 1;
    end
    check_eq("req40_in_tx", 64'(seen), 64'(1));
    arst_n = 0; #1;
    check_eq("req40_oe", 64'(bus.io_bus_oe), 64'(0));
    check_eq("req40_out_valid", 64'(bus.output_valid), 64'(0));
    check_eq("req40_bus_out", 64'(bus.io_bus_out), 64'(0));
    repeat (2) @(posedge clk);
    #3 arst_n = 1;
    tick(); bus.start = 1; tick(); bus.start = 0;
    oe_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick(); #2;
      if (bus.io_bus_oe) oe_cnt++;
    end
    check_eq("req40_fifo_empty", 64'(oe_cnt), 64'(0));

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      r1 = {$urandom, $urandom};
      r2 = {$urandom, $urandom};
      bus.start        = ($urandom % 16) == 0;
      bus.a_valid      = ($urandom % 3) == 0;
      bus.b_valid      = ($urandom % 3) == 0;
      bus.res_valid    = ($urandom % 3) == 0;
      bus.a_word_ready = ($urandom % 4) != 0;
      bus.b_word_ready = ($urandom % 4) != 0;
      bus.core_done    = ($urandom % 24) == 0;
      bus.io_bus_in    = r1[W-1:0];
      bus.res_word     = r2[W-1:0];
    end
    tick(); idle_inputs();
    repeat (40) tick();
    check_eq("drained", 64'(res_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/io_bus_ctrl.md
IO_BUS_CTRL -- requirements
Module: io_bus_ctrl

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 48, width of the shared bidirectional I/O word.
REQ-002 SHALL have parameter RES_FIFO_DEPTH, default 4, result-word buffer depth (power of two, >=2).
REQ-003 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port arst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  in  1  one-cycle pulse that begins a layer.
REQ-006 SHALL have port running  out  1  high from accepted start until the layer is finished.
REQ-007 SHALL have port io_bus_in  in  BUS_WIDTH  sampled pad value of the shared bus.
REQ-008 SHALL have port io_bus_out  out  BUS_WIDTH  value driven onto the bus when io_bus_oe=1.
REQ-009 SHALL have port io_bus_oe  out  1  chip drives the bus when 1, tristated when 0.
REQ-010 SHALL have ports a_valid in 1, a_ready out 1, the feature-word handshake from the driver.
REQ-011 SHALL have ports b_valid in 1, b_ready out 1, the kernel-word handshake from the driver.
REQ-012 SHALL have ports a_word out BUS_WIDTH, a_word_valid out 1, a_word_ready in 1, the feature stream to the core.
REQ-013 SHALL have ports b_word out BUS_WIDTH, b_word_valid out 1, b_word_ready in 1, the kernel stream to the core.
REQ-014 SHALL have ports res_word in BUS_WIDTH, res_valid in 1, res_ready out 1, the result stream from the core.
REQ-015 SHALL have port core_done  in  1  level; the core has produced its last result.
REQ-016 SHALL have port output_valid  out  1  io_bus_out carries a valid result word this cycle.
REQ-017 SHALL have port done  out  1  one-cycle pulse when the layer is complete.

Function
REQ-018 SHALL implement FSM states IDLE, RX, TURN_TX, TX, TURN_RX, FIN.
REQ-019 IDLE: start=1 -> RX next cycle, running=1; otherwise start is ignored in every non-IDLE state.
REQ-020 RX, oe=0: a_ready = ~a_buf_full | a_word_ready; b_ready = (same for b) & ~a_valid; a has fixed priority, so at most one bus word is accepted per cycle.
REQ-021 Accepted word SHALL be registered from io_bus_in and appear on a_word/b_word with *_word_valid=1 exactly 1 cycle later; held stable until *_word_ready=1.
REQ-022 res_ready = ~fifo_full in all states except IDLE; simultaneous push and pop SHALL keep the count unchanged.
REQ-023 RX -> TURN_TX when the FIFO is full, or when FIFO non-empty & ~a_valid & ~b_valid; RX -> FIN when core_done & FIFO empty & ~res_valid.
REQ-024 TURN_TX: one cycle, oe=0, a_ready=b_ready=0, output_valid=0, then TX.
REQ-025 TX: oe=1, output_valid=1, io_bus_out = FIFO head, one pop per cycle; a_ready=b_ready=0.
REQ-026 TX: when the last entry pops and no push occurs in the same cycle -> TURN_RX.
REQ-027 TURN_RX: one cycle, oe=0, all readies to the driver=0, then RX.
REQ-028 oe SHALL never be 1 in the same cycle as a_ready or b_ready (bus contention rule).
REQ-029 FIN: done=1 for one cycle, running=0 next, -> IDLE; internal buffers cleared.
REQ-030 io_bus_out SHALL be 0 whenever oe=0.
REQ-031 FIFO pointers SHALL wrap modulo RES_FIFO_DEPTH; count width = clog2(DEPTH)+1.

Reset
REQ-032 arst_n=0 SHALL immediately set state=IDLE, running=0, oe=0, io_bus_out=0, output_valid=0, done=0, a_ready=b_ready=res_ready=0, *_word_valid=0, FIFO empty.
REQ-033 Reset asserted mid-TX SHALL release the bus (oe=0) asynchronously; buffered results are discarded.
REQ-034 After deassertion the block SHALL remain in IDLE until the first start pulse.

Verification
REQ-035 start, then a_valid with word 48'h0000_0001_0002 -> a_ready=1; a_word=48'h0000_0001_0002 with a_word_valid=1 on the next cycle.
REQ-036 a_valid=b_valid=1 in the same cycle -> a accepted, b_ready=0; b accepted the following cycle once a_valid drops.
REQ-037 4 res pushes with driver idle -> TURN_TX (1 cycle), TX for 4 cycles with output_valid=1 in push order, TURN_RX, RX; oe never overlaps a_ready/b_ready.
REQ-038 FIFO full (4) and res_valid held -> res_ready=0 until the first TX pop; no word lost or duplicated.
REQ-039 core_done with FIFO empty in RX -> FIN, done pulse of 1 cycle, running=0, IDLE; a second start is accepted afterwards.
REQ-040 arst_n low during TX with 2 words pending -> oe=0 and output_valid=0 with no clock edge; FIFO empty after release.
